mfp_board_io_cond: RTL and testbench
====================================

# mfp_board_io_cond

Parametrised board-input conditioning block between raw FPGA board pins and `mfp_sys`. It synchronises and debounces N slide switches and N pushbuttons, and produces optional one-cycle press/release pulses. It also generates a stretched, synchronously released system reset from the board reset and pushbutton 0. Successor to direct pin-to-`IO_Switch`/`IO_PB` wiring in board top-levels, reusable across boards via parameters.

## Interface
- `N_SW`, default 10, number of slide-switch channels (≥1)
- `N_PB`, default 3, number of pushbutton channels (≥1); channel 0 is also the reset button
- `DEBOUNCE_CYCLES`, default 500000, cycles an input must hold a new level before it is accepted (≥1)
- `RESET_STRETCH`, default 16, cycles `sys_reset_n` stays low after every reset source has released (≥1)
- `SI_ClkIn`  in  1  system clock
- `SI_Reset_N`  in  1  asynchronous active-low reset
- `SW_raw`  in  N_SW  raw switch pins, asynchronous, active-high
- `KEY_raw`  in  N_PB  raw pushbutton pins, asynchronous, active-low (pressed = 0)
- `IO_Switch`  out  N_SW  debounced switch levels
- `IO_PB`  out  N_PB  debounced button levels, active-high (pressed = 1)
- `PB_press`  out  N_PB  one-cycle pulse when `IO_PB[i]` goes 0→1
- `PB_release`  out  N_PB  one-cycle pulse when `IO_PB[i]` goes 1→0
- `sys_reset_n`  out  1  conditioned active-low reset for `mfp_sys`

## Operation
- Reset values while `SI_Reset_N`=0: all synchroniser flops 0, all counters 0, `IO_Switch`=0, `IO_PB`=0, `PB_press`=0, `PB_release`=0, `sys_reset_n`=0, stretch counter 0.
- Each channel is independent. Input path: two-flop synchroniser. Button inputs are inverted before synchronisation, so internal polarity is active-high.
- Per-channel debouncer holds `stable` (drives the output) and `cnt`, with width $clog2(DEBOUNCE_CYCLES+1).
  - If `sync == stable`, then `cnt` ← 0.
  - If `sync != stable` and `cnt == DEBOUNCE_CYCLES-1`, then `stable` ← `sync` and `cnt` ← 0.
  - Otherwise `cnt` ← `cnt`+1.
  - A glitch that returns to `stable` before expiry clears `cnt`. No output change and no pulse.
- Edge pulses are registered: `PB_press[i]` = `stable` rose last cycle. Both pulse outputs are high for exactly one cycle. Press and release of the same channel never coincide.
- Reset generator:
  - Request = NOT synchronised `KEY_raw[0]`, undebounced. This gives a fast reset.
  - While the request is 1, `sys_reset_n`=0 and the stretch counter is 0.
  - Once the request is 0, the counter increments each cycle. `sys_reset_n` goes 1 on the cycle the counter reaches `RESET_STRETCH`, then the counter saturates.
  - A new request at any point clears the counter and drives `sys_reset_n`=0 on the next edge.
- `SI_Reset_N` asserting mid-operation clears all state immediately. This includes aborting any in-progress debounce count and pending pulses.

## Timing
- Debounce latency: a clean input change appears on the output 2 (synchroniser) + `DEBOUNCE_CYCLES` edges after the pin changes. Pulses appear 1 cycle after the output changes.
- After `SI_Reset_N` release with KEY[0] not pressed: `sys_reset_n` rises 2 + `RESET_STRETCH` edges later.
- After `SI_Reset_N` release, the first accepted switch level = 1 appears after 2 + `DEBOUNCE_CYCLES` edges. Switches at 0 stay 0 with no event.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `MFP_IO_COND_EDGE_EN`.
  - Defined: the edge-pulse registers and logic are built as described.
  - Undefined: `PB_press` and `PB_release` are tied to 0, and no edge registers are synthesised.
  - All other behaviour is identical either way.

## Test plan
The bench runs with `DEBOUNCE_CYCLES`=4, `RESET_STRETCH`=3, `N_SW`=2, `N_PB`=2, and `MFP_IO_COND_EDGE_EN` defined.
- Clean press: `KEY_raw[1]` goes 1→0 and is held 20 cycles → `IO_PB[1]`=1 exactly 6 edges later; `PB_press[1]`=1 for one cycle on the next edge; `PB_release`=0.
- Bounce: `SW_raw[0]` toggles 0,1,0,1 each cycle for 3 cycles, then holds 1 → `IO_Switch[0]` rises only 6 edges after the last transition; no intermediate change.
- Short glitch: `SW_raw[1]` is 1 for 3 cycles, then 0 → `IO_Switch[1]` stays 0 throughout.
- Reset button: `KEY_raw[0]`=0 for 2 cycles, then 1 → `sys_reset_n` goes 0 within 3 edges and returns 1 exactly 2 + 3 edges after the release is sampled. A second press during the stretch restarts the count.
- Async reset mid-debounce: assert `SI_Reset_N`=0 while a `SW_raw[0]` count is at 2 → all outputs 0 immediately, without waiting for a clock. After release, the held input is accepted only after the full 6 edges.
- Macro undefined: repeat the clean-press scenario → `IO_PB` behaves identically; `PB_press` and `PB_release` stay 0.

Source files
------------

// File: rtl/mfp_board_io_cond.sv
// Board input conditioning: 2-flop sync + debounce per switch/button lane, optional
// press/release pulses (MFP_IO_COND_EDGE_EN), and a stretched system reset from KEY[0].
module mfp_board_io_cond #(
    parameter int N_SW            = 10,
    parameter int N_PB            = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RESET_STRETCH   = 16
) (
    input  logic            SI_ClkIn,
    input  logic            SI_Reset_N,
    input  logic [N_SW-1:0] SW_raw,
    input  logic [N_PB-1:0] KEY_raw,
    output logic [N_SW-1:0] IO_Switch,
    output logic [N_PB-1:0] IO_PB,
    output logic [N_PB-1:0] PB_press,
    output logic [N_PB-1:0] PB_release,
    output logic            sys_reset_n
);
    localparam int NUM_LANES = N_SW + N_PB;
    localparam int CW        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Buttons are inverted ahead of the synchroniser so every lane is active-high.
    logic [NUM_LANES-1:0] lane_in;
    logic [NUM_LANES-1:0] lane_out;

    assign lane_in   = {~KEY_raw, SW_raw};
    assign IO_Switch = lane_out[N_SW-1:0];
    assign IO_PB     = lane_out[NUM_LANES-1:N_SW];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [1:0]    sync_q;
        logic          stable_q, stable_d;
        logic [CW-1:0] cnt_q, cnt_d;

        // Count consecutive mismatching samples; any agreement restarts the window.
        always_comb begin
            stable_d = stable_q;
            cnt_d    = '0;
            if (sync_q[1] != stable_q) begin
                if (cnt_q == CNT_LAST) stable_d = sync_q[1];
                else                   cnt_d    = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
            if (!SI_Reset_N) begin
                sync_q   <= '0;
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                sync_q   <= {sync_q[0], lane_in[i]};
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
            end
        end

        assign lane_out[i] = stable_q;
    end

`ifdef MFP_IO_COND_EDGE_EN
    logic [N_PB-1:0] pb_prev_q, press_q, release_q;

    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            pb_prev_q <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            pb_prev_q <= IO_PB;
            press_q   <= IO_PB & ~pb_prev_q;
            release_q <= ~IO_PB & pb_prev_q;
        end
    end

    assign PB_press   = press_q;
    assign PB_release = release_q;
`else
    assign PB_press   = '0;
    assign PB_release = '0;
`endif

    // Reset request uses its own raw-polarity sync so it reads as pressed
    // until the first real KEY[0] sample has propagated, and skips the debouncer.
    localparam int RCW = $clog2(RESET_STRETCH + 1);
    localparam logic [RCW-1:0] STRETCH_END = RCW'(RESET_STRETCH);

    logic [1:0]     rkey_q;
    logic           rst_req;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic           rstn_q, rstn_d;

    assign rst_req = ~rkey_q[1];

    always_comb begin
        rcnt_d = rcnt_q;
        if (rst_req)                    rcnt_d = '0;
        else if (rcnt_q != STRETCH_END) rcnt_d = rcnt_q + 1'b1;
        rstn_d = ~rst_req & (rcnt_d == STRETCH_END);
    end

    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            rkey_q <= '0;
            rcnt_q <= '0;
            rstn_q <= 1'b0;
        end else begin
            rkey_q <= {rkey_q[0], KEY_raw[0]};
            rcnt_q <= rcnt_d;
            rstn_q <= rstn_d;
        end
    end

    assign sys_reset_n = rstn_q;

endmodule

// File: tb/tb_mfp_board_io_cond.sv
// Scoreboard bench for mfp_board_io_cond: a window-based reference model predicts every
// cycle's outputs, a negedge monitor compares them, directed latency checks add boundaries.
module tb_mfp_board_io_cond;
    localparam int DB = 4;
    localparam int RS = 3;

    logic       SI_ClkIn = 1'b0;
    logic       SI_Reset_N;
    logic [1:0] SW_raw, KEY_raw;
    logic [1:0] IO_Switch, IO_PB, PB_press, PB_release;
    logic       sys_reset_n;

    mfp_board_io_cond #(.N_SW(2), .N_PB(2), .DEBOUNCE_CYCLES(DB), .RESET_STRETCH(RS)) dut (
        .SI_ClkIn(SI_ClkIn), .SI_Reset_N(SI_Reset_N), .SW_raw(SW_raw), .KEY_raw(KEY_raw),
        .IO_Switch(IO_Switch), .IO_PB(IO_PB), .PB_press(PB_press), .PB_release(PB_release),
        .sys_reset_n(sys_reset_n));

    always #5 SI_ClkIn = ~SI_ClkIn;

`ifdef MFP_IO_COND_EDGE_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [1:0] sw; logic [1:0] pb; logic [1:0] pr; logic [1:0] rl; logic rn;
    } exp_t;

    exp_t       sbq[$];
    logic [1:0] swh[$], pbh[$];
    logic       rkh[$];
    int         k = 0;
    logic [1:0] sw_m, pb_m, pb_prev;
    exp_t       e;

    // Internal value seen at edge j (j counted from 1 after reset release); before
    // release every synchroniser holds 0, i.e. switch off, button released, KEY[0] raw 0.
    function automatic logic hbit(input int src, input int j, input int c);
        logic [1:0] v;
        if (j < 1) return 1'b0;
        case (src)
            0:       v = swh[j-1];
            1:       v = pbh[j-1];
            default: v = {1'b0, rkh[j-1]};
        endcase
        return v[c];
    endfunction

    // Output flips once the 2-cycle-delayed input has shown the other level DB times running.
    function automatic logic flips(input int src, input int c, input logic s);
        for (int i = 0; i < DB; i++)
            if (hbit(src, k - 2 - i, c) == s) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge SI_ClkIn) begin
        if (!SI_Reset_N) begin
            k = 0;
            swh.delete(); pbh.delete(); rkh.delete();
            sw_m = '0; pb_m = '0; pb_prev = '0;
            e = '0;
        end else begin
            k++;
            swh.push_back(SW_raw);
            pbh.push_back(~KEY_raw);
            rkh.push_back(KEY_raw[0]);
            e.pr = EDGE_EN ? (pb_m & ~pb_prev) : 2'b00;
            e.rl = EDGE_EN ? (~pb_m & pb_prev) : 2'b00;
            pb_prev = pb_m;
            for (int c = 0; c < 2; c++) begin
                if (flips(0, c, sw_m[c])) sw_m[c] = ~sw_m[c];
                if (flips(1, c, pb_m[c])) pb_m[c] = ~pb_m[c];
            end
            e.sw = sw_m;
            e.pb = pb_m;
            e.rn = 1'b1;
            for (int i = 0; i < RS; i++)
                if (!hbit(2, k - 2 - i, 0)) e.rn = 1'b0;
        end
        sbq.push_back(e);
    end

    always @(negedge SI_ClkIn) begin
        exp_t x;
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk("IO_Switch", IO_Switch, x.sw);
            chk("IO_PB", IO_PB, x.pb);
            chk("PB_press", PB_press, x.pr);
            chk("PB_release", PB_release, x.rl);
            chk("sys_reset_n", sys_reset_n, x.rn);
        end
    end

    task automatic tick();
        @(posedge SI_ClkIn);
        #2;
    endtask

    // Edges from now until sig_sel goes high (0 = sys_reset_n, 1 = IO_PB[1], 2 = IO_Switch[0]).
    task automatic edges_until(input int sig_sel, output int n);
        logic v;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge SI_ClkIn);
            #1;
            case (sig_sel)
                0:       v = sys_reset_n;
                1:       v = IO_PB[1];
                default: v = IO_Switch[0];
            endcase
            if (v) begin n = i; break; end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        SI_Reset_N = 1'b0;
        SW_raw     = 2'b00;
        KEY_raw    = 2'b11;
        #2;
        chk("reset_outputs", {IO_Switch, IO_PB, PB_press, PB_release, sys_reset_n}, 9'd0);
        repeat (3) tick();
        SI_Reset_N = 1'b1;
        edges_until(0, n);
        chk("por_stretch_edges", n, 2 + RS);
        repeat (3) tick();

        // clean press on button 1
        KEY_raw[1] = 1'b0;
        edges_until(1, n);
        chk("press_latency_edges", n, 2 + DB);
        @(posedge SI_ClkIn); #1;
        chk("press_pulse", PB_press[1], EDGE_EN);
        chk("press_no_release", PB_release, 2'b00);
        repeat (14) tick();
        KEY_raw[1] = 1'b1;
        repeat (10) tick();

        // bouncing switch 0
        SW_raw[0] = 1'b1; tick();
        SW_raw[0] = 1'b0; tick();
        SW_raw[0] = 1'b1; tick();
        SW_raw[0] = 1'b0; tick();
        SW_raw[0] = 1'b1;
        repeat (12) tick();

        // short glitch on switch 1
        SW_raw[1] = 1'b1;
        repeat (3) tick();
        SW_raw[1] = 1'b0;
        repeat (10) tick();

        // reset button, then a second press during the stretch
        KEY_raw[0] = 1'b0;
        repeat (2) tick();
        KEY_raw[0] = 1'b1;
        edges_until(0, n);
        chk("button_stretch_edges", n, 2 + RS);
        tick();
        KEY_raw[0] = 1'b0; repeat (2) tick();
        KEY_raw[0] = 1'b1; repeat (2) tick();
        KEY_raw[0] = 1'b0; tick();
        KEY_raw[0] = 1'b1;
        repeat (12) tick();

        // async reset while switch 0 count sits at 2
        SW_raw[0] = 1'b0;
        repeat (10) tick();
        SW_raw[0] = 1'b1;
        repeat (4) tick();
        #4;
        SI_Reset_N = 1'b0;
        #1;
        chk("async_reset_outputs", {IO_Switch, IO_PB, PB_press, PB_release, sys_reset_n}, 9'd0);
        repeat (2) tick();
        SI_Reset_N = 1'b1;
        edges_until(2, n);
        chk("post_reset_accept_edges", n, 2 + DB);
        repeat (4) tick();

        // random hold lengths straddle the debounce window
        repeat (60) begin
            SW_raw  = 2'($urandom_range(0, 3));
            KEY_raw = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 7)) tick();
        end
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
